ctu_clsp_clkgn_syncpn: RTL and testbench

CTU_CLSP_CLKGN_SYNCPN -- requirements
Module: ctu_clsp_clkgn_syncpn

---
 rtl/ctu_clsp_syncp_pkg.sv | 21 ++
 rtl/ctu_clsp_syncp_rxch.sv | 69 ++++++
 rtl/ctu_clsp_clkgn_syncpn.sv | 112 +++++++++++
 tb/tb_ctu_clsp_clkgn_syncpn.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctu_clsp_syncp_pkg.sv
// ---------------------------------------------------------------------------
// ctu_clsp_syncp_pkg
// Shared constants for the CLSP sync-pulse generator: the default channel
// count and widths used by ctu_clsp_clkgn_syncpn, and the largest channel
// count the block is meant to be built with.
// ---------------------------------------------------------------------------
package ctu_clsp_syncp_pkg;

  // Default number of sync channels
  localparam int NCH_DEF = 3;

  // Default width of the shared tx down-counter and of tx match positions
  localparam int TXW_DEF = 5;

  // Default width of each channel's rx delay counter
  localparam int RXW_DEF = 2;

  // Largest supported channel count
  localparam int NCH_MAX = 8;

endpackage

// File: rtl/ctu_clsp_syncp_rxch.sv
// ---------------------------------------------------------------------------
// ctu_clsp_syncp_rxch
// One rx channel of the sync-pulse generator. A tx match arms the channel
// with a delay. The channel counts that delay down and then emits a
// registered one-cycle rx pulse. A second tx match while the channel is still
// waiting restarts the delay and flags a sticky overflow.
//
// Ports
//   cmp_clk     : clock, rising edge
//   cmp_rst     : synchronous active-high reset
//   coin_cnt_ld : counter load; clears all channel state
//   tx_match    : this channel's tx match in the current cycle
//   rx_dly      : rx delay loaded on tx match
//   rx_pend     : channel is waiting for its rx pulse
//   ovf_err     : sticky overflow flag
//   rx_sync     : registered one-cycle rx pulse
// ---------------------------------------------------------------------------
module ctu_clsp_syncp_rxch
  import ctu_clsp_syncp_pkg::*;
#(
  parameter int RXW = RXW_DEF
) (
  input  logic           cmp_clk,
  input  logic           cmp_rst,
  input  logic           coin_cnt_ld,
  input  logic           tx_match,
  input  logic [RXW-1:0] rx_dly,
  output logic           rx_pend,
  output logic           ovf_err,
  output logic           rx_sync
);

  logic [RXW-1:0] rx_cnt;
  logic           rx_match;

  // The rx match fires once the pending delay has counted down to zero
  assign rx_match = rx_pend & (rx_cnt == '0);

  // Channel state. A load drops any rx match in the same cycle. A tx match
  // always rearms the channel, even when it coincides with an rx match. In
  // that case the rx pulse is still emitted and no overflow is flagged.
  always_ff @(posedge cmp_clk) begin
    if (cmp_rst) begin
      rx_cnt  <= '0;
      rx_pend <= 1'b0;
      ovf_err <= 1'b0;
      rx_sync <= 1'b0;
    end else if (coin_cnt_ld) begin
      rx_cnt  <= '0;
      rx_pend <= 1'b0;
      ovf_err <= 1'b0;
      rx_sync <= 1'b0;
    end else begin
      rx_sync <= rx_match;
      if (tx_match) begin
        rx_cnt  <= rx_dly;
        rx_pend <= 1'b1;
        if (rx_pend && !rx_match) begin
          ovf_err <= 1'b1;
        end
      end else if (rx_match) begin
        rx_pend <= 1'b0;
      end else if (rx_pend) begin
        rx_cnt <= rx_cnt - RXW'(1);
      end
    end
  end

endmodule

// File: rtl/ctu_clsp_clkgn_syncpn.sv
// ---------------------------------------------------------------------------
// ctu_clsp_clkgn_syncpn
// Multi-channel sync-pulse generator. A shared down-counter is compared
// against a per-channel tx position. A match emits a registered tx pulse and
// arms that channel's rx delay, which then produces a delayed rx pulse.
// The counter is either periodic (it reloads at zero) or one-shot (it halts
// at zero until the next load).
//
// Ports
//   cmp_clk          : clock, rising edge
//   cmp_rst          : synchronous active-high reset
//   coin_cnt_en      : global enable for tx matches
//   coin_cnt_ld      : load the counter with clsp_sync_init; clear rx state
//   oneshot          : 1 = halt at zero, 0 = reload with clsp_sync_period
//   ch_en            : per-channel enable
//   clsp_sync_tx     : per-channel tx position, channel i at [i*TXW +: TXW]
//   clsp_sync_rx     : per-channel rx delay, channel i at [i*RXW +: RXW]
//   clsp_sync_init   : counter load value
//   clsp_sync_period : counter reload value
//   tx_sync_vec      : registered per-channel tx pulse
//   rx_sync_vec      : registered per-channel rx pulse
//   tx_sync, rx_sync : OR of the pulse vectors
//   rx_pend          : per-channel rx-waiting flag
//   ovf_err          : per-channel sticky overflow
// ---------------------------------------------------------------------------
module ctu_clsp_clkgn_syncpn
  import ctu_clsp_syncp_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int TXW = TXW_DEF,
  parameter int RXW = RXW_DEF
) (
  input  logic               cmp_clk,
  input  logic               cmp_rst,
  input  logic               coin_cnt_en,
  input  logic               coin_cnt_ld,
  input  logic               oneshot,
  input  logic [NCH-1:0]     ch_en,
  input  logic [NCH*TXW-1:0] clsp_sync_tx,
  input  logic [NCH*RXW-1:0] clsp_sync_rx,
  input  logic [TXW-1:0]     clsp_sync_init,
  input  logic [TXW-1:0]     clsp_sync_period,
  output logic [NCH-1:0]     tx_sync_vec,
  output logic [NCH-1:0]     rx_sync_vec,
  output logic               tx_sync,
  output logic               rx_sync,
  output logic [NCH-1:0]     rx_pend,
  output logic [NCH-1:0]     ovf_err
);

  logic [TXW-1:0] cnt;
  logic           halted;
  logic [NCH-1:0] tx_match;

  // Shared down-counter. In one-shot mode the counter parks at zero and sets
  // halted. Only a load or a reset releases it, even if oneshot is later
  // dropped.
  always_ff @(posedge cmp_clk) begin
    if (cmp_rst) begin
      cnt    <= '0;
      halted <= 1'b0;
    end else if (coin_cnt_ld) begin
      cnt    <= clsp_sync_init;
      halted <= 1'b0;
    end else if (cnt != '0) begin
      cnt <= cnt - TXW'(1);
    end else if (!oneshot) begin
      cnt <= clsp_sync_period;
    end else begin
      halted <= 1'b1;
    end
  end

  // Per-channel compare against the live counter. Positions are used
  // directly, so a new value is seen at the very next compare.
  always_comb begin
    tx_match = '0;
    for (int i = 0; i < NCH; i++) begin
      tx_match[i] = ch_en[i] & coin_cnt_en & ~coin_cnt_ld & ~halted &
                    (cnt == clsp_sync_tx[i*TXW +: TXW]);
    end
  end

  // Tx pulses are the matches delayed by one cycle
  always_ff @(posedge cmp_clk) begin
    if (cmp_rst) begin
      tx_sync_vec <= '0;
    end else begin
      tx_sync_vec <= tx_match;
    end
  end

  // Independent rx logic per channel
  for (genvar g = 0; g < NCH; g++) begin : g_rxch
    ctu_clsp_syncp_rxch #(
      .RXW (RXW)
    ) u_rxch (
      .cmp_clk     (cmp_clk),
      .cmp_rst     (cmp_rst),
      .coin_cnt_ld (coin_cnt_ld),
      .tx_match    (tx_match[g]),
      .rx_dly      (clsp_sync_rx[g*RXW +: RXW]),
      .rx_pend     (rx_pend[g]),
      .ovf_err     (ovf_err[g]),
      .rx_sync     (rx_sync_vec[g])
    );
  end

  assign tx_sync = |tx_sync_vec;
  assign rx_sync = |rx_sync_vec;

endmodule

// File: tb/tb_ctu_clsp_clkgn_syncpn.sv
// ---------------------------------------------------------------------------
// tb_ctu_clsp_clkgn_syncpn
// Directed self-checking bench for ctu_clsp_clkgn_syncpn with the default
// configuration (3 channels, 5-bit tx, 2-bit rx). Each step advances one
// clock and compares every output against hand-derived values. The counter
// value during cycle k after a load is noted as k:cnt in the comments.
// ---------------------------------------------------------------------------
module tb_ctu_clsp_clkgn_syncpn;

  logic        cmp_clk;
  logic        cmp_rst;
  logic        coin_cnt_en;
  logic        coin_cnt_ld;
  logic        oneshot;
  logic [2:0]  ch_en;
  logic [14:0] clsp_sync_tx;
  logic [5:0]  clsp_sync_rx;
  logic [4:0]  clsp_sync_init;
  logic [4:0]  clsp_sync_period;
  logic [2:0]  tx_sync_vec;
  logic [2:0]  rx_sync_vec;
  logic        tx_sync;
  logic        rx_sync;
  logic [2:0]  rx_pend;
  logic [2:0]  ovf_err;

  int checks;
  int failures;

  ctu_clsp_clkgn_syncpn dut (
    .cmp_clk          (cmp_clk),
    .cmp_rst          (cmp_rst),
    .coin_cnt_en      (coin_cnt_en),
    .coin_cnt_ld      (coin_cnt_ld),
    .oneshot          (oneshot),
    .ch_en            (ch_en),
    .clsp_sync_tx     (clsp_sync_tx),
    .clsp_sync_rx     (clsp_sync_rx),
    .clsp_sync_init   (clsp_sync_init),
    .clsp_sync_period (clsp_sync_period),
    .tx_sync_vec      (tx_sync_vec),
    .rx_sync_vec      (rx_sync_vec),
    .tx_sync          (tx_sync),
    .rx_sync          (rx_sync),
    .rx_pend          (rx_pend),
    .ovf_err          (ovf_err)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    cmp_clk = 1'b0;
    forever #5 cmp_clk = ~cmp_clk;
  end

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge cmp_clk);
    #1;
  endtask

  // Drive all non-reset inputs at once
  task automatic applyStimulus(input logic ld, input logic en, input logic one,
                               input logic [2:0] chen, input logic [14:0] tx,
                               input logic [5:0] rx, input logic [4:0] init,
                               input logic [4:0] period);
    coin_cnt_ld      = ld;
    coin_cnt_en      = en;
    oneshot          = one;
    ch_en            = chen;
    clsp_sync_tx     = tx;
    clsp_sync_rx     = rx;
    clsp_sync_init   = init;
    clsp_sync_period = period;
  endtask

  // Compare all outputs against the expected pulse/pend/ovf vectors
  task automatic checkOutput(input string tag, input logic [2:0] e_tx,
                             input logic [2:0] e_rx, input logic [2:0] e_pend,
                             input logic [2:0] e_ovf);
    checks++;
    assert (tx_sync_vec === e_tx) else begin
      failures++;
      $error("[TB] FAIL %s tx_sync_vec observed=%b expected=%b", tag, tx_sync_vec, e_tx);
    end
    checks++;
    assert (rx_sync_vec === e_rx) else begin
      failures++;
      $error("[TB] FAIL %s rx_sync_vec observed=%b expected=%b", tag, rx_sync_vec, e_rx);
    end
    checks++;
    assert (rx_pend === e_pend) else begin
      failures++;
      $error("[TB] FAIL %s rx_pend observed=%b expected=%b", tag, rx_pend, e_pend);
    end
    checks++;
    assert (ovf_err === e_ovf) else begin
      failures++;
      $error("[TB] FAIL %s ovf_err observed=%b expected=%b", tag, ovf_err, e_ovf);
    end
    checks++;
    assert (tx_sync === (|e_tx)) else begin
      failures++;
      $error("[TB] FAIL %s tx_sync observed=%b expected=%b", tag, tx_sync, |e_tx);
    end
    checks++;
    assert (rx_sync === (|e_rx)) else begin
      failures++;
      $error("[TB] FAIL %s rx_sync observed=%b expected=%b", tag, rx_sync, |e_rx);
    end
  endtask

  // Directed sequence
  initial begin
    checks   = 0;
    failures = 0;

    // Reset state
    cmp_rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 15'd0, 6'd0, 5'd0, 5'd0);
    tick();
    tick();
    checkOutput("reset", 3'b000, 3'b000, 3'b000, 3'b000);
    cmp_rst = 1'b0;

    // Periodic: init=4 period=9 tx={3,6,8} rx={0,1,2}
    // 0:4 1:3(ch0) 2:2 3:1 4:0 5:9 6:8(ch2) 7:7 8:6(ch1) 9:5 10:4 11:3(ch0)
    $display("[TB] periodic mode");
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b111, {5'd8, 5'd6, 5'd3},
                  {2'd2, 2'd1, 2'd0}, 5'd4, 5'd9);
    tick();
    coin_cnt_ld = 1'b0;
    checkOutput("per_k0", 3'b000, 3'b000, 3'b000, 3'b000);
    tick(); checkOutput("per_k1",  3'b000, 3'b000, 3'b000, 3'b000);
    tick(); checkOutput("per_k2",  3'b001, 3'b000, 3'b001, 3'b000);
    tick(); checkOutput("per_k3",  3'b000, 3'b001, 3'b000, 3'b000);
    tick(); checkOutput("per_k4",  3'b000, 3'b000, 3'b000, 3'b000);
    tick(); checkOutput("per_k5",  3'b000, 3'b000, 3'b000, 3'b000);
    tick(); checkOutput("per_k6",  3'b000, 3'b000, 3'b000, 3'b000);
    tick(); checkOutput("per_k7",  3'b100, 3'b000, 3'b100, 3'b000);
    tick(); checkOutput("per_k8",  3'b000, 3'b000, 3'b100, 3'b000);
    tick(); checkOutput("per_k9",  3'b010, 3'b000, 3'b110, 3'b000);
    tick(); checkOutput("per_k10", 3'b000, 3'b100, 3'b010, 3'b000);
    tick(); checkOutput("per_k11", 3'b000, 3'b010, 3'b000, 3'b000);
    tick(); checkOutput("per_k12", 3'b001, 3'b000, 3'b001, 3'b000);
    tick(); checkOutput("per_k13", 3'b000, 3'b001, 3'b000, 3'b000);

    // One-shot: init=5 tx0=0, only ch0 enabled; 5:0 match, then halted
    $display("[TB] oneshot mode");
    applyStimulus(1'b1, 1'b1, 1'b1, 3'b001, {5'd8, 5'd6, 5'd0},
                  {2'd2, 2'd1, 2'd0}, 5'd5, 5'd9);
    tick();
    coin_cnt_ld = 1'b0;
    checkOutput("os_k0", 3'b000, 3'b000, 3'b000, 3'b000);
    tick(); checkOutput("os_k1", 3'b000, 3'b000, 3'b000, 3'b000);
    tick(); checkOutput("os_k2", 3'b000, 3'b000, 3'b000, 3'b000);
    tick(); checkOutput("os_k3", 3'b000, 3'b000, 3'b000, 3'b000);
    tick(); checkOutput("os_k4", 3'b000, 3'b000, 3'b000, 3'b000);
    tick(); checkOutput("os_k5", 3'b000, 3'b000, 3'b000, 3'b000);
    tick(); checkOutput("os_k6", 3'b001, 3'b000, 3'b001, 3'b000);
    tick(); checkOutput("os_k7", 3'b000, 3'b001, 3'b000, 3'b000);
    for (int k = 8; k < 14; k++) begin
      tick(); checkOutput($sformatf("os_halt_k%0d", k), 3'b000, 3'b000, 3'b000, 3'b000);
    end
    // A new load re-arms the halted counter: init=1, 1:0 match
    applyStimulus(1'b1, 1'b1, 1'b1, 3'b001, {5'd8, 5'd6, 5'd0},
                  {2'd2, 2'd1, 2'd0}, 5'd1, 5'd9);
    tick();
    coin_cnt_ld = 1'b0;
    checkOutput("os_re_k0", 3'b000, 3'b000, 3'b000, 3'b000);
    tick(); checkOutput("os_re_k1", 3'b000, 3'b000, 3'b000, 3'b000);
    tick(); checkOutput("os_re_k2", 3'b001, 3'b000, 3'b001, 3'b000);
    tick(); checkOutput("os_re_k3", 3'b000, 3'b001, 3'b000, 3'b000);
    tick(); checkOutput("os_re_k4", 3'b000, 3'b000, 3'b000, 3'b000);

    // Overflow: ch_en=010, tx1=1 rx1=3 init=2 period=2; ch0/ch2 would also
    // match but are disabled. Matches at 1 and 4; the global enable is then
    // dropped, so the rx pulse lands 4 cycles after the second tx pulse.
    $display("[TB] overflow and channel disable");
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, {5'd2, 5'd1, 5'd1},
                  {2'd0, 2'd3, 2'd0}, 5'd2, 5'd2);
    tick();
    coin_cnt_ld = 1'b0;
    checkOutput("ovf_k0", 3'b000, 3'b000, 3'b000, 3'b000);
    tick(); checkOutput("ovf_k1", 3'b000, 3'b000, 3'b000, 3'b000);
    tick(); checkOutput("ovf_k2", 3'b010, 3'b000, 3'b010, 3'b000);
    tick(); checkOutput("ovf_k3", 3'b000, 3'b000, 3'b010, 3'b000);
    tick(); checkOutput("ovf_k4", 3'b000, 3'b000, 3'b010, 3'b000);
    tick(); checkOutput("ovf_k5", 3'b010, 3'b000, 3'b010, 3'b010);
    coin_cnt_en = 1'b0;
    tick(); checkOutput("ovf_k6", 3'b000, 3'b000, 3'b010, 3'b010);
    tick(); checkOutput("ovf_k7", 3'b000, 3'b000, 3'b010, 3'b010);
    tick(); checkOutput("ovf_k8", 3'b000, 3'b000, 3'b010, 3'b010);
    tick(); checkOutput("ovf_k9", 3'b000, 3'b010, 3'b000, 3'b010);
    tick(); checkOutput("ovf_k10", 3'b000, 3'b000, 3'b000, 3'b010);
    coin_cnt_ld = 1'b1;
    tick();
    coin_cnt_ld = 1'b0;
    checkOutput("ovf_ldclr", 3'b000, 3'b000, 3'b000, 3'b000);

    // Coincident tx/rx match: tx0=1 rx0=1 init=1 period=1; matches at 0,2,4
    $display("[TB] coincident tx and rx match");
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b001, {5'd2, 5'd1, 5'd1},
                  {2'd0, 2'd3, 2'd1}, 5'd1, 5'd1);
    tick();
    coin_cnt_ld = 1'b0;
    checkOutput("coin_k0", 3'b000, 3'b000, 3'b000, 3'b000);
    tick(); checkOutput("coin_k1", 3'b001, 3'b000, 3'b001, 3'b000);
    tick(); checkOutput("coin_k2", 3'b000, 3'b000, 3'b001, 3'b000);
    tick(); checkOutput("coin_k3", 3'b001, 3'b001, 3'b001, 3'b000);
    tick(); checkOutput("coin_k4", 3'b000, 3'b000, 3'b001, 3'b000);
    tick(); checkOutput("coin_k5", 3'b001, 3'b001, 3'b001, 3'b000);

    // Reset while all channels pend, with a simultaneous load request
    $display("[TB] reset mid-pending");
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b111, {5'd1, 5'd1, 5'd1},
                  {2'd3, 2'd3, 2'd3}, 5'd1, 5'd1);
    tick();
    coin_cnt_ld = 1'b0;
    checkOutput("rst_k0", 3'b000, 3'b000, 3'b000, 3'b000);
    tick(); checkOutput("rst_k1", 3'b111, 3'b000, 3'b111, 3'b000);
    cmp_rst     = 1'b1;
    coin_cnt_ld = 1'b1;
    tick(); checkOutput("rst_k2", 3'b000, 3'b000, 3'b000, 3'b000);
    cmp_rst     = 1'b0;
    coin_cnt_ld = 1'b0;
    coin_cnt_en = 1'b0;
    for (int k = 3; k < 9; k++) begin
      tick(); checkOutput($sformatf("rst_after_k%0d", k), 3'b000, 3'b000, 3'b000, 3'b000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
